// File: rtl/pll_reset_ctrl.sv
// Sequences the PLL reset, qualifies lock through a synchroniser and filter, and
// releases a lock-qualified system reset; retries on timeout and re-sequences on lock loss.
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked_in,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_fail,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_FILTER_CYCLES) ? RST_PULSE_CYCLES : LOCK_FILTER_CYCLES;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Held as raw bits so the undefined encodings 5..7 stay representable and decodable.
  logic [2:0]    state_r;
  logic          sync1;
  logic          locked_s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [RW-1:0] retry_next;

  assign state      = state_r;
  assign retry_next = retry + 1'b1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked_in;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESET_PLL;
      cnt         <= '0;
      retry       <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      lock_fail   <= 1'b0;
      loss_count  <= 8'd0;
    end else if (restart_req) begin
      // A requested restart is not a lock loss, so loss_count is left alone.
      state_r     <= RESET_PLL;
      cnt         <= '0;
      retry       <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      case (state_r)
        RESET_PLL: begin
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
          if (cnt == PULSE_LAST) begin
            state_r <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_r <= FILTER;
            cnt     <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry <= retry_next;
            cnt   <= '0;
            if (retry_next == RETRY_LIMIT) begin
              state_r   <= FAIL;
              lock_fail <= 1'b1;
            end else begin
              state_r <= RESET_PLL;
              pll_rst <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FILTER: begin
          // Any low sample restarts the lock wait with a fresh timeout but costs no retry.
          if (!locked_s) begin
            state_r <= WAIT_LOCK;
            cnt     <= '0;
          end else if (cnt == FILTER_LAST) begin
            state_r     <= RUN;
            cnt         <= '0;
            retry       <= '0;
            sys_reset_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          pll_rst     <= 1'b0;
          sys_reset_n <= 1'b1;
          if (!locked_s) begin
            state_r     <= RESET_PLL;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
          end
        end
        FAIL: begin
          pll_rst     <= 1'b0;
          sys_reset_n <= 1'b0;
          lock_fail   <= 1'b1;
        end
        default: begin
          state_r     <= RESET_PLL;
          cnt         <= '0;
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed stimulus pushes cycle-tagged expected outputs into a
// scoreboard queue; an independent monitor compares them on the falling edge (or on demand).
module tb_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked_in;
  logic       restart_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_fail;
  logic [2:0] state;
  logic [7:0] loss_count;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_FILTER_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .locked_in  (locked_in),
    .restart_req(restart_req),
    .pll_rst    (pll_rst),
    .sys_reset_n(sys_reset_n),
    .lock_fail  (lock_fail),
    .state      (state),
    .loss_count (loss_count)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic       prst;
    logic       srn;
    logic       lf;
    logic [7:0] lc;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   failed    = 0;
  event probe_ev;

  // cyc of -1 means "compare immediately when probe_ev fires".
  task automatic push_exp(input int c, input string name, input logic [2:0] st, input logic prst,
                          input logic srn, input logic lf, input logic [7:0] lc);
    exp_t e;
    e.cyc = c; e.name = name; e.st = st; e.prst = prst; e.srn = srn; e.lf = lf; e.lc = lc;
    q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    logic [13:0] got, want;
    got  = {state, pll_rst, sys_reset_n, lock_fail, loss_count};
    want = {e.st, e.prst, e.srn, e.lf, e.lc};
    tests_run++;
    if (e.cyc >= 0 && e.cyc < cyc) begin
      failed++;
      $display("[TB] FAIL %s missed at cyc %0d (now %0d)", e.name, e.cyc, cyc);
    end else if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s cyc=%0d got st=%0d prst=%b srn=%b lf=%b lc=%0d, want st=%0d prst=%b srn=%b lf=%b lc=%0d",
               e.name, cyc, state, pll_rst, sys_reset_n, lock_fail, loss_count,
               e.st, e.prst, e.srn, e.lf, e.lc);
    end
  endtask

  initial forever begin
    @(negedge refclk or probe_ev);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == -1 || q[i].cyc <= cyc) begin
        check_output(q[i]);
        q.delete(i);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic apply_restart();
    restart_req = 1'b1;
    wait_neg(1);
    restart_req = 1'b0;
  endtask

  int       t;
  logic [7:0] exp_lc;

  initial begin
    rst_n = 1'b0; locked_in = 1'b0; restart_req = 1'b0;
    wait_neg(2);
    push_exp(cyc + 1, "reset_values", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    wait_neg(2);

    // Power-up: 4-cycle pll_rst, then lock after 10 cycles, release 11 cycles after lock.
    rst_n = 1'b1; t = cyc;
    push_exp(t + 3, "pulse_last_high", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(t + 4, "enter_wait_lock", 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_neg(10);
    locked_in = 1'b1; t = cyc;
    push_exp(t + 2,  "sync_latency",   3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    push_exp(t + 3,  "filter_entry",   3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    push_exp(t + 10, "filter_no_early", 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    push_exp(t + 11, "first_release",  3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_neg(13);

    // Lock loss in RUN, then a one-cycle glitch during the following filter.
    locked_in = 1'b0; t = cyc;
    push_exp(t + 2, "run_before_loss", 3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
    push_exp(t + 3, "loss_reset",      3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    push_exp(t + 6, "loss_pulse_last", 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    push_exp(t + 7, "loss_wait_lock",  3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    wait_neg(8);
    locked_in = 1'b1; t = cyc;
    push_exp(t + 9,  "glitch_in_filter", 3'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    push_exp(t + 10, "glitch_to_wait",   3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    push_exp(t + 11, "glitch_refilter",  3'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    push_exp(t + 18, "glitch_no_early",  3'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    push_exp(t + 19, "glitch_release",   3'd3, 1'b0, 1'b1, 1'b0, 8'd1);
    wait_neg(7);
    locked_in = 1'b0;
    wait_neg(1);
    locked_in = 1'b1;
    wait_neg(12);

    // restart_req in RUN keeps loss_count.
    t = cyc;
    push_exp(t + 1,  "restart_run",      3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    push_exp(t + 4,  "restart_run_last", 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    push_exp(t + 5,  "restart_run_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    push_exp(t + 6,  "restart_run_filt", 3'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    push_exp(t + 14, "restart_run_rel",  3'd3, 1'b0, 1'b1, 1'b0, 8'd1);
    apply_restart();
    wait_neg(14);

    // 299 more losses; loss_count saturates at 255.
    exp_lc = 8'd1;
    for (int i = 0; i < 299; i++) begin
      locked_in = 1'b0; t = cyc;
      exp_lc = (exp_lc == 8'd255) ? 8'd255 : exp_lc + 8'd1;
      push_exp(t + 3, "loop_loss", 3'd0, 1'b1, 1'b0, 1'b0, exp_lc);
      wait_neg(8);
      locked_in = 1'b1; t = cyc;
      push_exp(t + 11, "loop_relock", 3'd3, 1'b0, 1'b1, 1'b0, exp_lc);
      wait_neg(12);
    end

    // Lock never returns: two timeouts, then FAIL.
    locked_in = 1'b0; t = cyc;
    push_exp(t + 3,  "sat_loss",        3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
    push_exp(t + 7,  "to_wait1",        3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    push_exp(t + 38, "to_wait1_last",   3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    push_exp(t + 39, "to_retry_pulse",  3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
    push_exp(t + 42, "to_pulse_last",   3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
    push_exp(t + 43, "to_wait2",        3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    push_exp(t + 74, "to_wait2_last",   3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    push_exp(t + 75, "enter_fail",      3'd4, 1'b0, 1'b0, 1'b1, 8'd255);
    push_exp(t + 85, "fail_held",       3'd4, 1'b0, 1'b0, 1'b1, 8'd255);
    wait_neg(86);

    // restart_req in FAIL clears lock_fail and the retry count.
    t = cyc;
    push_exp(t + 1,  "restart_fail",      3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
    push_exp(t + 4,  "restart_fail_last", 3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
    push_exp(t + 5,  "restart_fail_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    push_exp(t + 36, "retry_wait_last",   3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    push_exp(t + 37, "retry_cleared",     3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
    push_exp(t + 41, "retry_wait_again",  3'd1, 1'b0, 1'b0, 1'b0, 8'd255);
    apply_restart();
    wait_neg(40);

    // Asynchronous reset in the middle of FILTER.
    locked_in = 1'b1; t = cyc;
    push_exp(t + 3, "filter_before_rst", 3'd2, 1'b0, 1'b0, 1'b0, 8'd255);
    wait_neg(5);
    #2 rst_n = 1'b0;
    #1;
    push_exp(-1, "async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    -> probe_ev;
    locked_in = 1'b0;
    wait_neg(2);
    rst_n = 1'b1; t = cyc;
    push_exp(t + 4, "post_rst_wait", 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_neg(6);

    // Illegal encoding recovers to RESET_PLL on the next edge.
    t = cyc;
    force dut.state_r = 3'd5;
    #1 release dut.state_r;
    push_exp(t + 1, "illegal_recover",   3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(t + 4, "illegal_pulse_end", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(t + 5, "illegal_wait",      3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_neg(8);

    while (q.size() > 0) begin
      tests_run++;
      failed++;
      $display("[TB] FAIL %s never checked (due cyc %0d)", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
